// File: rtl/sequence_detector_param_if.sv
// Handshake/result bundle between a controller and the serial pattern detector.
// Latency: none, wires only.
// Backpressure: none; start is a level sampled every edge by the detector.
interface sequence_detector_param_if #(
   parameter int DATA_W = 16,
   parameter int PAT_W  = 5
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic              start;
   logic [DATA_W-1:0] data_in;
   logic [PAT_W-1:0]  pattern;
   logic              overlap;
   logic              busy;
   logic              done;
   logic              match;
   logic [CNT_W-1:0]  match_cnt;
   logic [CNT_W-1:0]  first_pos;
   logic              first_vld;
   logic              led;

   // Controller side: issues scans, observes results
   modport master (
      output start, data_in, pattern, overlap,
      input  busy, done, match, match_cnt, first_pos, first_vld, led
   );

   // Detector side
   modport slave (
      input  start, data_in, pattern, overlap,
      output busy, done, match, match_cnt, first_pos, first_vld, led
   );
endinterface

// File: rtl/sequence_detector_param.sv
// Scans a captured word MSB-first through a PAT_W-bit sliding window, counting pattern hits.
// Latency: start edge E0, bits consumed on E1..E_DATA_W, match visible the cycle after its last bit.
// Backpressure: none; start (level) always wins and re-arms the scan while held high.
module sequence_detector_param #(
   parameter int DATA_W = 16,
   parameter int PAT_W  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   sequence_detector_param_if.slave bus
);
   localparam int CNT_W  = $clog2(DATA_W + 1);
   localparam int IDX_W  = $clog2(DATA_W);
   localparam int FILL_W = $clog2(PAT_W + 1);

   // Reject illegal widths at elaboration time
   generate
      if (DATA_W < 2 || DATA_W > 64 || PAT_W < 1 || PAT_W > DATA_W) begin : g_bad_params
         $error("sequence_detector_param: illegal DATA_W/PAT_W combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_next;

   logic [DATA_W-1:0]  data_reg;
   logic [PAT_W-1:0]   pattern_reg;
   logic               overlap_reg;
   logic [IDX_W-1:0]   idx;
   logic [PAT_W-1:0]   window;
   logic [FILL_W-1:0]  fill;

   logic               match_r;
   logic [CNT_W-1:0]   match_cnt_r;
   logic [CNT_W-1:0]   first_pos_r;
   logic               first_vld_r;
   logic               led_r;

   logic               bit_cur;
   logic [PAT_W-1:0]   window_next;
   logic [FILL_W-1:0]  fill_next;
   logic               hit;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state: start re-arms from anywhere; SCAN ends after the bit at index 0
   always_comb begin
      state_next = state;
      if (bus.start) begin
         state_next = SCAN;
      end else begin
         case (state)
            IDLE:    state_next = IDLE;
            SCAN:    state_next = (idx == '0) ? DONE : SCAN;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Window step for the current bit; a cast shift keeps PAT_W=1 legal
   always_comb begin
      bit_cur     = data_reg[idx];
      window_next = PAT_W'({window, bit_cur});
      fill_next   = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
      hit         = (fill_next == FILL_W'(PAT_W)) && (window_next == pattern_reg);
   end

   // Capture on start, consume one bit per edge in SCAN, hold results otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_reg    <= '0;
         pattern_reg <= '0;
         overlap_reg <= 1'b0;
         idx         <= '0;
         window      <= '0;
         fill        <= '0;
         match_r     <= 1'b0;
         match_cnt_r <= '0;
         first_pos_r <= '0;
         first_vld_r <= 1'b0;
         led_r       <= 1'b0;
      end else if (bus.start) begin
         data_reg    <= bus.data_in;
         pattern_reg <= bus.pattern;
         overlap_reg <= bus.overlap;
         idx         <= IDX_W'(DATA_W - 1);
         window      <= '0;
         fill        <= '0;
         match_r     <= 1'b0;
         match_cnt_r <= '0;
         first_pos_r <= '0;
         first_vld_r <= 1'b0;
         led_r       <= 1'b0;
      end else if (state == SCAN) begin
         match_r <= hit;
         window  <= window_next;
         fill    <= fill_next;
         if (hit) begin
            if (match_cnt_r != '1) match_cnt_r <= match_cnt_r + CNT_W'(1);
            if (!first_vld_r) begin
               first_pos_r <= CNT_W'(idx);
               first_vld_r <= 1'b1;
               led_r       <= 1'b1;
            end
            // Non-overlapping mode: the next match must be built from fresh bits
            if (!overlap_reg) begin
               window <= '0;
               fill   <= '0;
            end
         end
         if (idx != '0) idx <= idx - IDX_W'(1);
      end else begin
         match_r <= 1'b0;
      end
   end

   // All outputs come straight from registers
   assign bus.busy      = (state == SCAN);
   assign bus.done      = (state == DONE);
   assign bus.match     = match_r;
   assign bus.match_cnt = match_cnt_r;
   assign bus.first_pos = first_pos_r;
   assign bus.first_vld = first_vld_r;
   assign bus.led       = led_r;
endmodule

// File: tb/tb_sequence_detector_param.sv
// Bench for sequence_detector_param: directed scenarios plus random scans vs a window-slicing model.
module tb_sequence_detector_param;
   localparam int DATA_W = 8;
   localparam int PAT_W  = 5;
   localparam int CNT_W  = $clog2(DATA_W + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sequence_detector_param_if #(.DATA_W(DATA_W), .PAT_W(PAT_W)) bus ();

   sequence_detector_param #(.DATA_W(DATA_W), .PAT_W(PAT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // exp_hit[n] = 1 when the bit consumed on edge En completes a counted match
   bit exp_hit [0:DATA_W];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: the bits consumed on edges n-PAT_W+1..n are data[DATA_W-n +: PAT_W];
   // without overlap a new match may only use bits consumed after the previous match.
   task automatic run_model(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p, input bit ov);
      int last = 0;
      logic [DATA_W-1:0] sh;
      for (int n = 0; n <= DATA_W; n++) exp_hit[n] = 1'b0;
      for (int n = PAT_W; n <= DATA_W; n++) begin
         sh = d >> (DATA_W - n);
         if ((ov || (n - PAT_W >= last)) && (sh[PAT_W-1:0] == p)) begin
            exp_hit[n] = 1'b1;
            last = n;
         end
      end
   endtask

   // Present start with the given operands for 'hold' edges, then scramble the inputs
   task automatic drive_start(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p,
                              input bit ov, input int hold, input string tag);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.data_in = d;
      bus.pattern = p;
      bus.overlap = ov;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({tag, "_arm_busy"}, bus.busy, 1);
         check({tag, "_arm_done"}, bus.done, 0);
         check({tag, "_arm_cnt"},  bus.match_cnt, 0);
         check({tag, "_arm_led"},  bus.led, 0);
         check({tag, "_arm_vld"},  bus.first_vld, 0);
      end
      @(negedge clk);
      bus.start   = 1'b0;
      bus.data_in = DATA_W'($urandom);
      bus.pattern = PAT_W'($urandom);
      bus.overlap = 1'($urandom);
   endtask

   // Follow edges E1..E_DATA_W against the model, then confirm DONE holds the results
   task automatic scan_check(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p,
                             input bit ov, input string tag);
      int cnt = 0;
      int fpos = 0;
      bit fvld = 0;
      run_model(d, p, ov);
      for (int e = 1; e <= DATA_W; e++) begin
         @(posedge clk); #1;
         if (exp_hit[e]) begin
            cnt++;
            if (!fvld) begin
               fvld = 1;
               fpos = DATA_W - e;
            end
         end
         check({tag, "_match"}, bus.match, 32'(exp_hit[e]));
         check({tag, "_cnt"},   bus.match_cnt, cnt);
         check({tag, "_busy"},  bus.busy, 32'(e < DATA_W));
         check({tag, "_done"},  bus.done, 32'(e == DATA_W));
      end
      check({tag, "_first_vld"}, bus.first_vld, 32'(fvld));
      check({tag, "_first_pos"}, bus.first_pos, fpos);
      check({tag, "_led"},       bus.led, 32'(fvld));
      repeat (2) begin
         @(posedge clk); #1;
         check({tag, "_hold_done"},  bus.done, 1);
         check({tag, "_hold_busy"},  bus.busy, 0);
         check({tag, "_hold_match"}, bus.match, 0);
         check({tag, "_hold_cnt"},   bus.match_cnt, cnt);
         check({tag, "_hold_pos"},   bus.first_pos, fpos);
         check({tag, "_hold_led"},   bus.led, 32'(fvld));
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"},  bus.busy, 0);
      check({tag, "_done"},  bus.done, 0);
      check({tag, "_match"}, bus.match, 0);
      check({tag, "_cnt"},   bus.match_cnt, 0);
      check({tag, "_pos"},   bus.first_pos, 0);
      check({tag, "_vld"},   bus.first_vld, 0);
      check({tag, "_led"},   bus.led, 0);
   endtask

   initial begin
      logic [DATA_W-1:0] d;
      logic [PAT_W-1:0]  p;
      bit                ov;
      int                off;

      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.data_in = '0;
      bus.pattern = '0;
      bus.overlap = 1'b0;

      // Reset state, then idle with start low must stay idle
      #12;
      check_idle_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("idle");

      // Overlapping matches on 10010010
      drive_start(8'b10010010, 5'b10010, 1'b1, 1, "s1");
      scan_check(8'b10010010, 5'b10010, 1'b1, "s1");

      // Non-overlapping: second match shares bits with the first
      drive_start(8'b10010010, 5'b10010, 1'b0, 1, "s2");
      scan_check(8'b10010010, 5'b10010, 1'b0, "s2");

      // No match at all
      drive_start(8'h00, 5'b10010, 1'b1, 1, "s3");
      scan_check(8'h00, 5'b10010, 1'b1, "s3");

      // All ones, both modes
      drive_start(8'hFF, 5'b11111, 1'b1, 1, "s4o");
      scan_check(8'hFF, 5'b11111, 1'b1, "s4o");
      drive_start(8'hFF, 5'b11111, 1'b0, 1, "s4n");
      scan_check(8'hFF, 5'b11111, 1'b0, "s4n");

      // Held start keeps re-arming without consuming bits
      drive_start(8'b10010010, 5'b10010, 1'b1, 4, "hold");
      scan_check(8'b10010010, 5'b10010, 1'b1, "hold");

      // Restart sampled on E3 of a scan
      drive_start(8'b10010010, 5'b10010, 1'b1, 1, "rs1");
      repeat (2) @(posedge clk);
      drive_start(8'h00, 5'b10010, 1'b1, 1, "rs1b");
      scan_check(8'h00, 5'b10010, 1'b1, "rs1b");

      // Restart after a match has already set led and the count
      drive_start(8'b10010010, 5'b10010, 1'b1, 1, "rs2");
      repeat (5) @(posedge clk);
      #1;
      check("rs2_pre_led", bus.led, 1);
      drive_start(8'h00, 5'b10010, 1'b1, 1, "rs2b");
      scan_check(8'h00, 5'b10010, 1'b1, "rs2b");

      // Asynchronous reset mid-scan, between edges, just after the first match
      drive_start(8'b10010010, 5'b10010, 1'b1, 1, "ar");
      repeat (5) @(posedge clk);
      #3;
      check("ar_pre_match", bus.match, 1);
      rst = 1'b1;
      #1;
      check_idle_zero("ar_async");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         check("ar_no_done", bus.done, 0);
         check("ar_no_busy", bus.busy, 0);
      end

      // Random scans; half the patterns are lifted from the word to force hits
      for (int t = 0; t < 40; t++) begin
         d  = DATA_W'($urandom);
         p  = PAT_W'($urandom);
         ov = 1'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            off = $urandom_range(0, DATA_W - PAT_W);
            d   = d;
            p   = PAT_W'(d >> off);
         end
         drive_start(d, p, ov, $urandom_range(1, 2), "rnd");
         scan_check(d, p, ov, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
